// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_CORE = 1'b0;
  localparam port_id_t PORT_DBG  = 1'b1;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-RAM arbiter: request/grant plus registered read return.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_lock_watchdog.sv
// Starvation watchdog: counts core wait cycles while locked and forces a core grant.
module lock_watchdog #(
  parameter int MAX_LOCK = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  input  logic req_core,
  input  logic gnt_core,
  output logic force_core
);
  localparam logic [7:0] LIMIT = 8'(MAX_LOCK);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!locked || gnt_core) begin
      wait_cnt <= '0;
    end else if (req_core && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Force once the core has waited MAX_LOCK full cycles under lock.
  assign force_core = locked && (wait_cnt >= LIMIT);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the 256x32 data RAM with debug burst lock.
//   state  | meaning
//   ARB    | round-robin between core (port 0) and debug loader (port 1)
//   LOCKED | debug port has priority; core served when idle debug or watchdog fires
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         p0,
  dmem_arbiter_if.slave         p1,
  input  logic                  dbg_lock,
  output logic                  core_stall,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  import arb_pkg::*;

  arb_state_t            state, state_next;
  port_id_t              prio;
  rd_owner_t             rd_owner;
  logic                  force_core;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] hold0, hold1;

  lock_watchdog #(.MAX_LOCK(MAX_LOCK)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .locked     (state == LOCKED),
    .req_core   (p0.req),
    .gnt_core   (gnt0),
    .force_core (force_core)
  );

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (p0.req && p1.req) begin
      if (state == LOCKED) begin
        if (force_core) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (prio == PORT_CORE) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = p0.req;
      gnt1 = p1.req;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (gnt1 && dbg_lock) state_next = LOCKED;
      LOCKED:  if (!dbg_lock)        state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      prio  <= PORT_CORE;
    end else begin
      state <= state_next;
      if (gnt0)      prio <= PORT_DBG;
      else if (gnt1) prio <= PORT_CORE;
    end
  end

  always_comb begin
    ram_wen   = 1'b0;
    ram_ren   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_wen   = p0.we;
      ram_ren   = ~p0.we;
      ram_addr  = p0.addr;
      ram_wdata = p0.wdata;
    end else if (gnt1) begin
      ram_wen   = p1.we;
      ram_ren   = ~p1.we;
      ram_addr  = p1.addr;
      ram_wdata = p1.wdata;
    end
  end

  // The RAM output register is the data register; the hold copy keeps it stable between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner <= '0;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      rd_owner.valid <= ram_ren;
      rd_owner.port  <= gnt1 ? PORT_DBG : PORT_CORE;
      if (rvalid0) hold0 <= ram_rdata;
      if (rvalid1) hold1 <= ram_rdata;
    end
  end

  assign rvalid0    = rd_owner.valid && (rd_owner.port == PORT_CORE);
  assign rvalid1    = rd_owner.valid && (rd_owner.port == PORT_DBG);
  assign p0.gnt     = gnt0;
  assign p1.gnt     = gnt1;
  assign p0.rvalid  = rvalid0;
  assign p1.rvalid  = rvalid1;
  assign p0.rdata   = rvalid0 ? ram_rdata : hold0;
  assign p1.rdata   = rvalid1 ? ram_rdata : hold1;
  assign core_stall = p0.req && !gnt0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a per-cycle reference model and RAM model.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int ML = 4;

  logic          clk;
  logic          rst;
  logic          dbg_lock;
  logic          core_stall, ram_wen, ram_ren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (p0_if),
    .p1         (p1_if),
    .dbg_lock   (dbg_lock),
    .core_stall (core_stall),
    .ram_wen    (ram_wen),
    .ram_ren    (ram_ren),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ram_rdata = '0;
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_addr];
    if (ram_wen) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as the rules describe it, advanced once per cycle.
  int            m_prio, m_stalls;
  bit            m_locked, m_rv_valid;
  int            m_rv_port;
  logic [DW-1:0] m_rv_data;
  logic [DW-1:0] m_hold [2];

  always @(negedge clk) begin
    int            eg;
    bit            r0, r1, gwe;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    if (rst) begin
      chk("rst_gnt0", p0_if.gnt, 0);
      chk("rst_gnt1", p1_if.gnt, 0);
      chk("rst_rvalid0", p0_if.rvalid, 0);
      chk("rst_rvalid1", p1_if.rvalid, 0);
      chk("rst_rdata0", p0_if.rdata, 0);
      chk("rst_rdata1", p1_if.rdata, 0);
      chk("rst_ram_strobes", {ram_wen, ram_ren}, 0);
      m_prio = 0; m_stalls = 0; m_locked = 0; m_rv_valid = 0;
      m_rv_port = 0; m_rv_data = '0; m_hold[0] = '0; m_hold[1] = '0;
    end else begin
      r0 = p0_if.req;
      r1 = p1_if.req;
      if (r0 && r1)  eg = m_locked ? ((m_stalls >= ML) ? 0 : 1) : m_prio;
      else if (r0)   eg = 0;
      else if (r1)   eg = 1;
      else           eg = -1;
      gwe = (eg == 0) ? p0_if.we    : (eg == 1) ? p1_if.we    : 1'b0;
      ga  = (eg == 0) ? p0_if.addr  : (eg == 1) ? p1_if.addr  : '0;
      gd  = (eg == 0) ? p0_if.wdata : (eg == 1) ? p1_if.wdata : '0;

      chk("gnt0", p0_if.gnt, eg == 0);
      chk("gnt1", p1_if.gnt, eg == 1);
      chk("core_stall", core_stall, r0 && eg != 0);
      chk("ram_wen", ram_wen, eg >= 0 && gwe);
      chk("ram_ren", ram_ren, eg >= 0 && !gwe);
      chk("ram_addr", ram_addr, ga);
      chk("ram_wdata", ram_wdata, gd);
      chk("rvalid0", p0_if.rvalid, m_rv_valid && m_rv_port == 0);
      chk("rvalid1", p1_if.rvalid, m_rv_valid && m_rv_port == 1);
      chk("rdata0", p0_if.rdata, (m_rv_valid && m_rv_port == 0) ? m_rv_data : m_hold[0]);
      chk("rdata1", p1_if.rdata, (m_rv_valid && m_rv_port == 1) ? m_rv_data : m_hold[1]);

      if (m_rv_valid) m_hold[m_rv_port] = m_rv_data;
      m_rv_valid = (eg >= 0) && !gwe;
      m_rv_port  = (eg == 1) ? 1 : 0;
      m_rv_data  = ref_mem[ga];
      if (eg >= 0 && gwe) ref_mem[ga] = gd;

      if (!m_locked || eg == 0) m_stalls = 0;
      else if (r0)              m_stalls++;
      m_locked = m_locked ? dbg_lock : (eg == 1 && dbg_lock);
      if (eg >= 0) m_prio = 1 - eg;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit req, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (p == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
    end
  endtask

  initial begin
    logic [5:0] rr_seq;
    logic [3:0] un_seq;
    int         n_gnt0, n_stall;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA5A5_0000 | 32'(i);
      ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    mem[8'h10]     = 32'hDEAD_BEEF;
    ref_mem[8'h10] = 32'hDEAD_BEEF;

    rst = 1'b1;
    dbg_lock = 1'b0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    step(); step();
    rst = 1'b0;
    step();

    // single core read of 0x10
    drive(0, 1, 0, 8'h10, '0);
    #3;
    chk("t1_gnt0", p0_if.gnt, 1);
    chk("t1_gnt1", p1_if.gnt, 0);
    step();
    drive(0, 0, 0, '0, '0);
    #3;
    chk("t1_rvalid0", p0_if.rvalid, 1);
    chk("t1_rdata0", p0_if.rdata, 32'hDEAD_BEEF);
    chk("t1_rvalid1", p1_if.rvalid, 0);
    step();

    // single loader read so contention starts from core priority
    drive(1, 1, 0, 8'h11, '0);
    step();
    drive(1, 0, 0, '0, '0);
    #3;
    chk("t2_rdata1", p1_if.rdata, 32'hA5A5_0011);
    step();

    // both read every cycle
    drive(0, 1, 0, 8'h12, '0);
    drive(1, 1, 0, 8'h13, '0);
    for (int i = 0; i < 6; i++) begin
      #3;
      rr_seq[i] = p1_if.gnt;
      step();
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    chk("rr_seq", 32'(rr_seq), 32'b101010);
    step();

    // loader write then core read-back
    drive(1, 1, 1, 8'h20, 32'h1234_5678);
    #3;
    chk("wr_gnt1", p1_if.gnt, 1);
    step();
    drive(1, 0, 0, '0, '0);
    drive(0, 1, 0, 8'h20, '0);
    #3;
    chk("rb_gnt0", p0_if.gnt, 1);
    step();
    drive(0, 0, 0, '0, '0);
    #3;
    chk("rb_rdata0", p0_if.rdata, 32'h1234_5678);
    step();

    // burst lock with watchdog
    dbg_lock = 1'b1;
    drive(0, 1, 0, 8'h14, '0);
    drive(1, 1, 0, 8'h15, '0);
    n_gnt0 = 0;
    n_stall = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      n_gnt0  += int'(p0_if.gnt);
      n_stall += int'(core_stall);
      step();
    end
    chk("lock_gnt0_count", n_gnt0, 3);
    chk("lock_stall_count", n_stall, 17);

    // release lock
    dbg_lock = 1'b0;
    #3;
    chk("unlock_force_gnt0", p0_if.gnt, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      #3;
      un_seq[i] = p1_if.gnt;
      step();
    end
    chk("unlock_seq", 32'(un_seq), 32'b0101);
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    step();

    // reset while a read is in flight
    drive(0, 1, 0, 8'h10, '0);
    step();
    drive(0, 0, 0, '0, '0);
    rst = 1'b1;
    #3;
    chk("rstmid_rvalid0", p0_if.rvalid, 0);
    chk("rstmid_rdata0", p0_if.rdata, 0);
    step(); step();
    rst = 1'b0;
    #3;
    chk("post_rst_rvalid0", p0_if.rvalid, 0);
    step();
    drive(0, 1, 0, 8'h30, '0);
    #3;
    chk("post_rst_gnt0", p0_if.gnt, 1);
    step();
    drive(0, 0, 0, '0, '0);
    #3;
    chk("post_rst_rvalid0b", p0_if.rvalid, 1);
    chk("post_rst_rdata0", p0_if.rdata, 32'hA5A5_0030);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data RAM (256 × 32) between two requesters: the core load/store port (port 0) and the debug/program loader (port 1). Sits between the core datapath and `Ram`. It arbitrates round-robin, issues one RAM access per cycle, and returns registered read data with a valid strobe. A starvation watchdog guarantees the core still progresses while the loader holds a burst lock.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM word-address width (matches 256-deep RAM)
- DATA_WIDTH, 32, data width
- MAX_LOCK, 16, max consecutive lock-granted port-1 cycles while port 0 waits; range 1..255

Ports (p ∈ {0,1}):
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_p  in  1  access request; requester holds req/we/addr/wdata stable until gnt_p
- we_p  in  1  1 = write, 0 = read
- addr_p  in  ADDR_WIDTH  word address
- wdata_p  in  DATA_WIDTH  write data
- gnt_p  out  1  access accepted this cycle (combinational)
- rvalid_p  out  1  read data valid (registered)
- rdata_p  out  DATA_WIDTH  read data (registered, held until next rvalid_p)
- dbg_lock  in  1  port-1 burst lock request
- core_stall  out  1  req_0 & ~gnt_0; drives the PC-hold enable
- ram_wen, ram_ren  out  1  RAM strobes
- ram_addr  out  ADDR_WIDTH; ram_wdata  out  DATA_WIDTH
- ram_rdata  in  DATA_WIDTH  synchronous read, valid the cycle after ram_ren

## Operation
- At most one grant per cycle. The granted port's addr/wdata/we drive the RAM the same cycle. With no grant: ram_wen = ram_ren = 0, and ram_addr/ram_wdata are 0.
- Round-robin pointer `prio`, reset value 0:
  - both requesting → grant `prio`, then `prio` ← other port
  - one requesting → grant it, and `prio` ← other port
- Lock FSM states:
  - ARB: normal round-robin.
  - LOCKED: port 1 has absolute priority; port 0 is granted only if req_1 = 0, or by the watchdog.
  - Transitions:
    - ARB→LOCKED when gnt_1 & dbg_lock.
    - LOCKED→ARB when dbg_lock = 0 (sampled at the edge).
- Watchdog counter `wait_cnt` (8 bit):
  - In LOCKED: increments each cycle req_0 & ~gnt_0; clears on gnt_0.
  - When wait_cnt = MAX_LOCK−1, the next cycle with req_0 forces gnt_0 regardless of req_1, then clears. The FSM stays LOCKED.
  - In ARB: held at 0.
- Reads: rvalid_p pulses 1 cycle for each granted read; rdata_p ← ram_rdata on that cycle. Writes produce no rvalid.
- Tracking register `rd_owner` (valid bit + port id) records which port's read is in flight.

## Timing
- Reset values: gnt_* 0 (no req in reset), rvalid_* 0, rdata_* 0, state ARB, prio 0, wait_cnt 0, rd_owner invalid.
- Read latency: gnt in cycle N → rvalid/rdata in cycle N+1. Back-to-back reads give 1 result per cycle.
- Write completes at the edge ending the gnt cycle. A read of the same address granted at N+1 returns the new data.
- Simultaneous read completion and new grant: independent, both allowed in the same cycle.
- Reset asserted mid-read: in-flight rvalid is suppressed; no spurious rvalid after reset release.
- req dropped before gnt: legal; no state change.
- dbg_lock asserted with req_1 = 0: no effect until port 1 is granted.

## Structure
- Package `arb_pkg`: `arb_state_t` enum {ARB, LOCKED}, `port_id_t` (1 bit), constants PORT_CORE = 0, PORT_DBG = 1.
- One sub-module, `lock_watchdog`: wait_cnt counter, MAX_LOCK compare, force_core output.
- Top-level: grant logic, prio register, FSM, RAM mux, read-return register.
- Expected size: ~200 lines of RTL.

## Test plan
- Reset then a single port-0 read of addr 0x10, RAM preloaded 0xDEADBEEF → gnt_0 in cycle N; rvalid_0 = 1 and rdata_0 = 0xDEADBEEF in N+1; port 1 sees nothing.
- Both ports read every cycle for 6 cycles → grants alternate 0,1,0,1,0,1; each rvalid lands 1 cycle after its grant on the correct port.
- Port 1 writes 0x12345678 to 0x20, port 0 reads 0x20 the next cycle → rdata_0 = 0x12345678.
- dbg_lock held with port 1 requesting continuously, port 0 requesting, MAX_LOCK = 4 → gnt_0 once every 5 cycles; core_stall high in the other 4 cycles.
- Drop dbg_lock → FSM returns to ARB; next contended cycles alternate grants.
- rst asserted the cycle after a granted read → rvalid_0 stays 0; all outputs at reset values; after release, a fresh request is granted normally.
